// File: rtl/rf80386_pkg.sv
// Shared types for the rf80386 Wishbone target.
//   e_cyc_type  : CPU bus cycle type carried on cyc_type_i.
//   e_tgt_state : handshake FSM state of the target.
//   DatIdle     : value driven on dat_o when no read data is presented.
package rf80386_pkg;

  typedef enum logic [2:0] {
    CT_PASSIVE = 3'd0,
    CT_CODE    = 3'd1,
    CT_RDMEM   = 3'd2,
    CT_WRMEM   = 3'd3,
    CT_INTA    = 3'd4
  } e_cyc_type;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck
  } e_tgt_state;

  localparam logic [7:0] DatIdle = 8'hFF;

  // Offset of the spurious vector returned when nothing is pending.
  localparam logic [7:0] SpurOfs = 8'd7;

endpackage

// File: rtl/rf80386_prio_enc8.sv
// Lowest-index-first priority encoder.
//   req_i : 8 request bits
//   idx_o : index of the lowest-numbered set bit (0 when none set)
//   vld_o : at least one request bit set
module rf80386_prio_enc8 (
  input  logic [7:0] req_i,
  output logic [2:0] idx_o,
  output logic       vld_o
);

  always_comb begin
    idx_o = 3'd0;
    vld_o = |req_i;
    // Scan downward so the lowest set bit is the final assignment.
    for (int i = 7; i >= 0; i--) begin
      if (req_i[i]) idx_o = 3'(i);
    end
  end

endmodule

// File: rtl/rf80386_wb_target.sv
// Byte-wide Wishbone RAM target with optional 8-input interrupt controller.
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   cyc_type_i         : CPU cycle type (e_cyc_type)
//   cyc_i/stb_i/we_i   : Wishbone handshake; lock_i accepted but ignored
//   adr_i, dat_i       : 20-bit byte address, write data
//   dat_o, ack_o       : read data / interrupt vector (8'hFF when idle), acknowledge
//   irq_i, irq_o       : rising-edge interrupt lines, any-pending flag
// Define RF80386_INTA_EN to build the interrupt logic; otherwise irq_o is 0 and
// INTA cycles are never acknowledged.
module rf80386_wb_target
  import rf80386_pkg::*;
#(
  parameter int unsigned WAIT     = 1,
  parameter int unsigned ABITS    = 16,
  parameter logic [19:0] BASE     = 20'hF,
  parameter logic [7:0]  VEC_BASE = 8'h08
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [2:0]  cyc_type_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic        lock_i,
  input  logic [19:0] adr_i,
  input  logic [7:0]  dat_i,
  output logic [7:0]  dat_o,
  output logic        ack_o,
  input  logic [7:0]  irq_i,
  output logic        irq_o
);

  localparam logic [2:0] WaitLast = (WAIT == 0) ? 3'd0 : 3'(WAIT - 1);

  e_tgt_state state_q, state_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] inta_dat;
  logic       win_hit, is_mem, is_inta, sel, ack_rise, mem_we;
  logic [7:0] mem_q [2**ABITS];

  logic unused_lock;
  assign unused_lock = lock_i;

  always_comb begin
    win_hit = (adr_i[19:ABITS] == BASE[19-ABITS:0]);
    is_mem  = cyc_type_i inside {CT_CODE, CT_RDMEM, CT_WRMEM};
`ifdef RF80386_INTA_EN
    is_inta = (cyc_type_i == CT_INTA);
`else
    is_inta = 1'b0;
`endif
    sel = cyc_i & stb_i & ((win_hit & is_mem) | is_inta);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      StIdle: begin
        if (sel) begin
          if (WAIT == 0) begin
            state_d = StAck;
          end else begin
            state_d = StWait;
            wcnt_d  = 3'd0;
          end
        end
      end
      StWait: begin
        if (!(cyc_i && stb_i)) begin
          state_d = StIdle;
          wcnt_d  = 3'd0;
        end else if (wcnt_q == WaitLast) begin
          state_d = StAck;
          wcnt_d  = 3'd0;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      StAck: begin
        if (!stb_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Transfer takes effect once, on the edge where ack rises.
  always_comb begin
    ack_rise = (state_q != StAck) && (state_d == StAck);
    rdata_d  = rdata_q;
    if (ack_rise) rdata_d = is_inta ? inta_dat : mem_q[adr_i[ABITS-1:0]];
    mem_we = ack_rise & we_i & ~is_inta & rst_ni;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      wcnt_q  <= 3'd0;
      rdata_q <= DatIdle;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[adr_i[ABITS-1:0]] <= dat_i;
  end

  // Outputs
  always_comb begin
    ack_o = (state_q == StAck);
    dat_o = (ack_o && !we_i) ? rdata_q : DatIdle;
  end

`ifdef RF80386_INTA_EN
  logic [7:0] irq_hist_q, pending_q, pending_d, pend_clr;
  logic       inta_phase_q, inta_phase_d;
  logic [2:0] pick_idx;
  logic       pick_vld;

  rf80386_prio_enc8 u_prio (
    .req_i (pending_q),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  always_comb begin
    pend_clr     = 8'd0;
    inta_phase_d = inta_phase_q;
    inta_dat     = DatIdle;
    if (inta_phase_q) begin
      inta_dat = pick_vld ? (VEC_BASE + {5'd0, pick_idx}) : (VEC_BASE + SpurOfs);
    end
    if (ack_rise && is_inta) begin
      inta_phase_d = ~inta_phase_q;
      if (inta_phase_q && pick_vld) pend_clr = 8'd1 << pick_idx;
    end
    // A fresh edge overrides a clear on the same bit.
    pending_d = (pending_q & ~pend_clr) | (irq_i & ~irq_hist_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      irq_hist_q   <= 8'd0;
      pending_q    <= 8'd0;
      inta_phase_q <= 1'b0;
    end else begin
      irq_hist_q   <= irq_i;
      pending_q    <= pending_d;
      inta_phase_q <= inta_phase_d;
    end
  end

  assign irq_o = |pending_q;
`else
  logic unused_irq;
  assign unused_irq = ^irq_i;
  assign inta_dat   = DatIdle;
  assign irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_rf80386_wb_target.sv
module tb_rf80386_wb_target;
  import rf80386_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, cyc, stb, stb3, we, lock;
  logic [2:0]  ct;
  logic [19:0] adr;
  logic [7:0]  dat, irq;
  logic [7:0]  dat_o, dat3;
  logic        ack, ack3, irq_o, irq3;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  rf80386_wb_target #(.WAIT(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .cyc_type_i(ct), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .lock_i(lock), .adr_i(adr), .dat_i(dat), .dat_o(dat_o), .ack_o(ack), .irq_i(irq),
    .irq_o(irq_o)
  );

  rf80386_wb_target #(.WAIT(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .cyc_type_i(ct), .cyc_i(cyc), .stb_i(stb3), .we_i(we),
    .lock_i(lock), .adr_i(adr), .dat_i(dat), .dat_o(dat3), .ack_o(ack3), .irq_i(irq),
    .irq_o(irq3)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [19:0] a, input logic w, input e_cyc_type t,
                       input logic [7:0] d, input bit on3);
    adr = a; we = w; ct = t; dat = d; cyc = 1'b1;
    if (on3) stb3 = 1'b1;
    else stb = 1'b1;
  endtask

  task automatic stop();
    cyc = 1'b0; stb = 1'b0; stb3 = 1'b0; we = 1'b0; ct = CT_PASSIVE;
  endtask

  task automatic inta_cycle(input string tag, input logic [7:0] exp);
    start(20'h00000, 1'b0, CT_INTA, 8'h00, 1'b0);
    tick(); chk({tag, "_wait"}, ack, 8'd0);
    tick(); chk({tag, "_ack"}, ack, 8'd1); chk({tag, "_vec"}, dat_o, exp);
    stop();
    tick(); chk({tag, "_drop"}, ack, 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; stb3 = 1'b0; we = 1'b0; lock = 1'b0;
    adr = '0; dat = '0; ct = CT_PASSIVE; irq = '0;
    repeat (3) tick();
    chk("rst_ack", ack, 8'd0);
    chk("rst_dat", dat_o, 8'hFF);
    chk("rst_irq", irq_o, 8'd0);
    chk("rst_ack3", ack3, 8'd0);
    chk("rst_dat3", dat3, 8'hFF);
    chk("rst_irq3", irq3, 8'd0);
    rst_n = 1'b1;

    // Write then read with one wait state
    start(20'hF1234, 1'b1, CT_WRMEM, 8'h5A, 1'b0);
    tick(); chk("wr_wait", ack, 8'd0);
    tick(); chk("wr_ack", ack, 8'd1); chk("wr_dat_ff", dat_o, 8'hFF);
    stop();
    tick(); chk("wr_drop", ack, 8'd0);
    start(20'hF1234, 1'b0, CT_RDMEM, 8'h00, 1'b0);
    tick(); chk("rd_wait", ack, 8'd0);
    tick(); chk("rd_ack", ack, 8'd1); chk("rd_dat", dat_o, 8'h5A);
    tick(); chk("rd_hold", ack, 8'd1); chk("rd_hold_dat", dat_o, 8'h5A);
    stop();
    tick(); chk("rd_drop", ack, 8'd0); chk("rd_drop_dat", dat_o, 8'hFF);

    // Held ack must not rewrite with changed data
    start(20'hF0001, 1'b1, CT_WRMEM, 8'h11, 1'b0);
    tick(); tick(); chk("hold_wr_ack", ack, 8'd1);
    dat = 8'h22;
    tick(); tick(); chk("hold_wr_still", ack, 8'd1);
    stop(); tick();
    start(20'hF0001, 1'b0, CT_CODE, 8'h00, 1'b0);
    tick(); tick(); chk("code_rd", dat_o, 8'h11);
    stop(); tick();

    // Three wait states, aborted write keeps old value
    start(20'hF0010, 1'b1, CT_WRMEM, 8'h77, 1'b1);
    repeat (3) begin tick(); chk("w3_wait", ack3, 8'd0); end
    tick(); chk("w3_ack", ack3, 8'd1);
    stop(); tick();
    start(20'hF0010, 1'b1, CT_WRMEM, 8'h99, 1'b1);
    tick(); chk("abort_w1", ack3, 8'd0);
    tick(); chk("abort_w2", ack3, 8'd0);
    stop();
    repeat (4) begin tick(); chk("abort_noack", ack3, 8'd0); end
    start(20'hF0010, 1'b0, CT_RDMEM, 8'h00, 1'b1);
    repeat (3) begin tick(); chk("r3_wait", ack3, 8'd0); end
    tick(); chk("r3_ack", ack3, 8'd1); chk("r3_old", dat3, 8'h77);
    stop(); tick();

    // Outside the window: never acked
    start(20'h01234, 1'b0, CT_RDMEM, 8'h00, 1'b0);
    repeat (20) begin tick(); chk("outwin_ack", ack, 8'd0); end
    chk("outwin_dat", dat_o, 8'hFF);
    stop(); tick();

    // Passive cycle inside the window: never acked
    start(20'hF1234, 1'b0, CT_PASSIVE, 8'h00, 1'b0);
    repeat (5) begin tick(); chk("passive_ack", ack, 8'd0); end
    stop(); tick();

`ifdef RF80386_INTA_EN
    irq = 8'h24;
    tick(); chk("irq_set", irq_o, 8'd1);
    inta_cycle("inta1", 8'hFF); chk("irq_after1", irq_o, 8'd1);
    inta_cycle("inta2", 8'h0A); chk("irq_after2", irq_o, 8'd1);
    inta_cycle("inta3", 8'hFF);
    inta_cycle("inta4", 8'h0D); chk("irq_after4", irq_o, 8'd0);

    // New edge on bit 2 coincides with its clear
    irq = 8'h00; tick();
    irq = 8'h04; tick(); chk("irq2_set", irq_o, 8'd1);
    irq = 8'h00; tick();
    inta_cycle("inta5", 8'hFF);
    start(20'h00000, 1'b0, CT_INTA, 8'h00, 1'b0);
    tick(); chk("race_wait", ack, 8'd0);
    irq = 8'h04;
    tick(); chk("race_ack", ack, 8'd1); chk("race_vec", dat_o, 8'h0A);
    chk("race_pending", u_dut.pending_q, 8'h04);
    stop();
    tick(); chk("race_irq", irq_o, 8'd1);
    inta_cycle("inta7", 8'hFF);
    chk("phase_one", u_dut.inta_phase_q, 8'd1);
`else
    irq = 8'h24;
    start(20'h00000, 1'b0, CT_INTA, 8'h00, 1'b0);
    repeat (6) begin tick(); chk("inta_off_ack", ack, 8'd0); end
    chk("irq_off", irq_o, 8'd0);
    stop(); irq = 8'h00; tick();
`endif

    // Reset mid-write suppresses the write; restart right after reset
    start(20'hF0020, 1'b1, CT_WRMEM, 8'h33, 1'b0);
    tick(); tick(); chk("pre_wr_ack", ack, 8'd1);
    stop(); tick();
    start(20'hF0020, 1'b1, CT_WRMEM, 8'h44, 1'b0);
    tick(); rst_n = 1'b0;
    tick(); chk("rstwr_ack", ack, 8'd0);
    rst_n = 1'b1; stop();
    start(20'hF0020, 1'b0, CT_RDMEM, 8'h00, 1'b0);
    tick(); chk("restart_wait", ack, 8'd0);
    tick(); chk("restart_ack", ack, 8'd1); chk("rstwr_kept", dat_o, 8'h33);
    stop(); tick();

    // Reset during ACK of a read
    start(20'hF1234, 1'b0, CT_RDMEM, 8'h00, 1'b0);
    tick(); tick(); chk("rstack_pre", ack, 8'd1);
    rst_n = 1'b0;
    tick(); chk("rstack_ack", ack, 8'd0); chk("rstack_dat", dat_o, 8'hFF);
    chk("rstack_irq", irq_o, 8'd0);
`ifdef RF80386_INTA_EN
    chk("rstack_phase", u_dut.inta_phase_q, 8'd0);
`endif
    rst_n = 1'b1; stop(); tick();
    start(20'hF1234, 1'b0, CT_RDMEM, 8'h00, 1'b0);
    tick(); tick(); chk("ram_kept", dat_o, 8'h5A);
    stop(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
